// File: rtl/copy_scheduler.sv
// Frame-synchronous blit sequencer: snapshots a shadow job table on frame start and issues each
// valid slot, in slot order, to the copy_engine over a 4-phase execute/done handshake.
module copy_scheduler #(
    parameter int unsigned NUM_SLOTS      = 8,
    parameter int unsigned SRC_ADDR_WIDTH = 14
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         frame_start_i,
    input  logic                         cfg_we_i,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot_i,
    input  logic                         cfg_valid_i,
    input  logic [9:0]                   cfg_x_i,
    input  logic [9:0]                   cfg_y_i,
    input  logic [9:0]                   cfg_w_i,
    input  logic [9:0]                   cfg_h_i,
    input  logic [SRC_ADDR_WIDTH-1:0]    cfg_src_i,
    output logic [9:0]                   ce_dest_x_start_o,
    output logic [9:0]                   ce_dest_x_end_o,
    output logic [9:0]                   ce_dest_y_start_o,
    output logic [9:0]                   ce_dest_y_end_o,
    output logic [SRC_ADDR_WIDTH-1:0]    ce_src_addr_start_o,
    output logic                         ce_execute_o,
    input  logic                         ce_done_i,
    output logic                         busy_o,
    output logic                         overrun_o,
    output logic [$clog2(NUM_SLOTS):0]   jobs_issued_o
);

    localparam int unsigned IdxW = $clog2(NUM_SLOTS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_SLOTS - 1);
    localparam logic [10:0] XMax = 11'd639;
    localparam logic [10:0] YMax = 11'd479;

    typedef struct packed {
        logic                      valid;
        logic [9:0]                x;
        logic [9:0]                y;
        logic [9:0]                w;
        logic [9:0]                h;
        logic [SRC_ADDR_WIDTH-1:0] src;
    } slot_t;

    typedef enum logic [1:0] {StIdle, StScan, StIssue, StWaitClr} state_e;

    slot_t  shadow_q [NUM_SLOTS];
    slot_t  active_q [NUM_SLOTS];
    slot_t  cur;
    state_e state_q, state_d;

    logic [IdxW-1:0]           idx_q, idx_d;
    logic [IdxW:0]             jobs_q, jobs_d;
    logic                      exec_q, exec_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;
    logic [9:0]                xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [SRC_ADDR_WIDTH-1:0] src_q, src_d;

    logic        accept, last, runnable;
    logic [10:0] x_sum, y_sum;
    logic [9:0]  x_end, y_end;

    assign cur      = active_q[idx_q];
    assign accept   = frame_start_i && !busy_q;
    assign last     = (idx_q == LastIdx);
    assign x_sum    = {1'b0, cur.x} + {1'b0, cur.w} - 11'd1;
    assign y_sum    = {1'b0, cur.y} + {1'b0, cur.h} - 11'd1;
    assign x_end    = (x_sum > XMax) ? XMax[9:0] : x_sum[9:0];
    assign y_end    = (y_sum > YMax) ? YMax[9:0] : y_sum[9:0];
    assign runnable = cur.valid && (|cur.w) && (|cur.h) &&
                      ({1'b0, cur.x} <= XMax) && ({1'b0, cur.y} <= YMax);

    // A write coinciding with an accepted frame_start lands in the shadow only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (cfg_we_i) begin
                shadow_q[cfg_slot_i] <= '{valid: cfg_valid_i, x: cfg_x_i, y: cfg_y_i,
                                          w: cfg_w_i, h: cfg_h_i, src: cfg_src_i};
            end
            if (accept) begin
                for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            jobs_q    <= '0;
            exec_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            xs_q      <= '0;
            xe_q      <= '0;
            ys_q      <= '0;
            ye_q      <= '0;
            src_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            jobs_q    <= jobs_d;
            exec_q    <= exec_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            xs_q      <= xs_d;
            xe_q      <= xe_d;
            ys_q      <= ys_d;
            ye_q      <= ye_d;
            src_q     <= src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        jobs_d  = jobs_q;
        exec_d  = exec_q;
        xs_d    = xs_q;
        xe_d    = xe_q;
        ys_d    = ys_q;
        ye_d    = ye_q;
        src_d   = src_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StScan;
                    idx_d   = '0;
                    jobs_d  = '0;
                end
            end
            StScan: begin
                if (runnable) begin
                    xs_d    = cur.x;
                    xe_d    = x_end;
                    ys_d    = cur.y;
                    ye_d    = y_end;
                    src_d   = cur.src;
                    exec_d  = 1'b1;
                    state_d = StIssue;
                end else if (last) begin
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StIssue: begin
                if (ce_done_i) begin
                    exec_d  = 1'b0;
                    jobs_d  = jobs_q + 1'b1;
                    state_d = StWaitClr;
                end
            end
            StWaitClr: begin
                if (!ce_done_i) begin
                    if (last) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StScan;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // busy covers the return cycle into idle, so a frame_start there counts as an overrun.
        busy_d    = (state_d != StIdle) || (state_q != StIdle);
        overrun_d = overrun_q || (frame_start_i && busy_q);
    end

    assign ce_dest_x_start_o   = xs_q;
    assign ce_dest_x_end_o     = xe_q;
    assign ce_dest_y_start_o   = ys_q;
    assign ce_dest_y_end_o     = ye_q;
    assign ce_src_addr_start_o = src_q;
    assign ce_execute_o        = exec_q;
    assign busy_o              = busy_q;
    assign overrun_o           = overrun_q;
    assign jobs_issued_o       = jobs_q;

endmodule

// File: doc/copy_scheduler.md
Name: copy_scheduler

Overview:
Sequences the copy_engine through a per-frame list of sprite blits (background tiles, zombies, player) so only one requester owns the engine at a time. Software/game logic programs a shadow job table. On each frame start the table is snapshotted and every valid slot is issued to the copy_engine in slot order using a 4-phase execute/done handshake. The block sits between game logic and copy_engine and drives the engine's dest/src configuration ports.

Parameters:
NUM_SLOTS, 8, number of job table entries (power of 2, 2..32)
SRC_ADDR_WIDTH, 14, width of the sprite memory source address (matches copy_engine)

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  single-cycle pulse, start of blank interval
cfg_we  in  1  write one shadow slot this cycle
cfg_slot  in  $clog2(NUM_SLOTS)  slot index for the write
cfg_valid  in  1  slot enable
cfg_x, cfg_y  in  10 each  destination top-left pixel
cfg_w, cfg_h  in  10 each  sprite width/height in pixels
cfg_src  in  SRC_ADDR_WIDTH  sprite source start address
ce_dest_x_start, ce_dest_x_end  out  10 each  to copy_engine
ce_dest_y_start, ce_dest_y_end  out  10 each  to copy_engine
ce_src_addr_start  out  SRC_ADDR_WIDTH  to copy_engine
ce_execute  out  1  copy_engine start request
ce_done  in  1  copy_engine completion level
busy  out  1  frame job list in progress
overrun  out  1  sticky: frame_start arrived while busy
jobs_issued  out  $clog2(NUM_SLOTS)+1  jobs completed in the current/last frame

Behaviour:
- Reset (async assert, sync deassert in use): state IDLE, all ce_* outputs 0, busy=0, overrun=0, jobs_issued=0, all shadow and active valid bits 0.
- Shadow table: cfg_we writes slot cfg_slot at posedge, in any state. Never read directly by the sequencer.
- Active table: full copy of the shadow taken on the edge frame_start is accepted in IDLE. A cfg write in the same cycle lands in the shadow only and is not in this frame's snapshot.
- States: IDLE, SCAN, ISSUE, WAIT_CLR.
- IDLE: on frame_start, snapshot; idx=0; jobs_issued=0; busy=1; go to SCAN.
- SCAN (one cycle per slot): if slot idx is valid and w!=0 and h!=0, register ce_* configuration, assert ce_execute, go to ISSUE. Otherwise skip it. If idx was the last slot, go to IDLE with busy=0; else idx+1.
- ISSUE: hold ce_execute=1 and the config stable until ce_done=1. Then drop ce_execute, increment jobs_issued, go to WAIT_CLR.
- WAIT_CLR: wait for ce_done=0. Then, if idx was the last slot, go to IDLE and busy=0; else idx+1 and go to SCAN.
- Configuration outputs must not change while ce_execute=1 or in WAIT_CLR.
- Latency: ce_execute rises on the 2nd edge after frame_start is sampled if slot 0 is valid. Each skipped slot adds 1 cycle. After an engine job, the next SCAN occurs 1 cycle after ce_done falls.
- Geometry:
  - x_end = x + w - 1 and y_end = y + h - 1, computed 11-bit.
  - If x_end > 639, saturate to 639. If y_end > 479, saturate to 479.
  - If x > 639 or y > 479, skip the slot as invalid.
  - src unchanged.
- frame_start while busy: ignored (no snapshot, sequence continues) and overrun set to 1. overrun clears only on reset.
- reset_n low mid-job: immediate return to reset state with ce_execute=0. The copy_engine is responsible for aborting on its own reset.
- All slots invalid: SCAN walks NUM_SLOTS cycles, then IDLE with jobs_issued=0. No ce_execute pulse.

Test Plan:
1. Reset, then slot0 = {x=470,y=290,w=101,h=101,src=0}, others invalid, frame_start -> ce_execute on 2nd edge with x 470..570, y 290..390, src 0. Model done after 50 cycles, drop after 2 -> busy falls after slot 7 scan, jobs_issued=1.
2. Slots 1,3,6 valid with distinct src (100,200,300) -> three handshakes in order 100,200,300. Config stable while execute high. jobs_issued=3.
3. Slot0 {x=600,y=450,w=100,h=100} -> x_end=639, y_end=479. Slot1 {x=640,...} skipped, never issued.
4. Second frame_start during slot0 job -> overrun=1, no restart. Slot order and jobs_issued unaffected. overrun stays 1 through the next frame.
5. cfg write to slot 2 mid-frame -> not issued this frame, issued on the next frame_start. A cfg write coinciding with frame_start is also deferred.
6. reset_n low while ce_execute=1 -> ce_execute=0 and busy=0 asynchronously. After release, frame_start with an empty table -> no execute, busy high exactly NUM_SLOTS+1 cycles.
